// File: rtl/t5_pkg.sv
// Shared definitions for the t5 data-bus controller: opcodes, access sizes
// and the bus FSM state encoding.
package t5_pkg;

    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dwb_state_t;

    // True when the execute-stage slot carries a load or a store.
    function automatic logic is_memop(input logic vld, input logic [4:0] opc);
        return vld & ((opc == OPC_LOAD) | (opc == OPC_STORE));
    endfunction

endpackage

// File: rtl/t5_dwb_lane.sv
// Byte-lane decode for t5 data accesses: lane select, replicated store data
// and misalignment detection from funct3 and the low address bits.
module t5_dwb_lane
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      fn3,
    input  logic [1:0]      alo,
    input  logic [XLEN-1:0] rs2,
    output logic [3:0]      sel,
    output logic [XLEN-1:0] dto,
    output logic            mis
);

    // Decode access size into lanes; size 3 is illegal and flagged misaligned.
    always_comb begin
        sel = 4'h0;
        dto = rs2;
        mis = 1'b0;
        case (fn3[1:0])
            SZ_BYTE: begin
                sel = 4'b0001 << alo;
                dto = {4{rs2[7:0]}};
            end
            SZ_HALF: begin
                sel = alo[1] ? 4'hC : 4'h3;
                dto = {2{rs2[15:0]}};
                mis = alo[0];
            end
            SZ_WORD: begin
                sel = 4'hF;
                dto = rs2;
                mis = (alo != 2'b00);
            end
            default: begin
                sel = 4'h0;
                dto = rs2;
                mis = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/t5_dwb_ctl.sv
// t5 data Wishbone controller: launches one bus cycle per aligned load/store,
// stalls the pipeline (sena) until ack, then offers one DONE cycle carrying
// lane select and read data to writeback.
// Optional: define T5_DWB_TIMEOUT_EN to abort a BUSY cycle after TMO cycles
// without ack and report it on dtmo.
module t5_dwb_ctl
    import t5_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TMO  = 255
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            xvld,
    input  logic [4:0]      xopc,
    input  logic [2:0]      xfn3,
    input  logic [XLEN-1:0] xalu,
    input  logic [XLEN-1:0] xrs2,
    output logic [XLEN-1:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_wre,
    input  logic [XLEN-1:0] dwb_dti,
    input  logic            dwb_ack,
`ifdef T5_DWB_TIMEOUT_EN
    output logic            dtmo,
`endif
    output logic            sena,
    output logic [3:0]      xsel,
    output logic            xstb,
    output logic            xwre,
    output logic [XLEN-1:0] ldat,
    output logic            dmis
);

    dwb_state_t      state_r;
    logic [XLEN-1:0] adr_r;
    logic [XLEN-1:0] dto_r;
    logic [3:0]      sel_r;
    logic            stb_r;
    logic            wre_r;
    logic [3:0]      xsel_r;
    logic            xstb_r;
    logic            xwre_r;
    logic [XLEN-1:0] ldat_r;

    logic [3:0]      lane_sel_s;
    logic [XLEN-1:0] lane_dto_s;
    logic            lane_mis_s;
    logic            memop_s;

`ifdef T5_DWB_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tcnt_r;
    logic          dtmo_r;
`endif

    t5_dwb_lane #(.XLEN(XLEN)) u_lane (
        .fn3 (xfn3),
        .alo (xalu[1:0]),
        .rs2 (xrs2),
        .sel (lane_sel_s),
        .dto (lane_dto_s),
        .mis (lane_mis_s)
    );

    assign memop_s = is_memop(xvld, xopc);

    // Pipeline enable and misalignment pulse depend on the op waiting in IDLE,
    // so they are decoded combinationally from the current state and inputs.
    always_comb begin
        sena = 1'b0;
        dmis = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sena = ~(memop_s & ~lane_mis_s);
                dmis = memop_s & lane_mis_s;
            end
            ST_BUSY: begin
                sena = 1'b0;
                dmis = 1'b0;
            end
            ST_DONE: begin
                sena = 1'b1;
                dmis = 1'b0;
            end
            default: begin
                sena = 1'b1;
                dmis = 1'b0;
            end
        endcase
    end

    // Bus FSM: IDLE launches, BUSY waits for ack (or timeout), DONE hands off.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state_r <= ST_IDLE;
            adr_r   <= '0;
            dto_r   <= '0;
            sel_r   <= 4'h0;
            stb_r   <= 1'b0;
            wre_r   <= 1'b0;
            xsel_r  <= 4'h0;
            xstb_r  <= 1'b0;
            xwre_r  <= 1'b0;
            ldat_r  <= '0;
`ifdef T5_DWB_TIMEOUT_EN
            tcnt_r  <= '0;
            dtmo_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (memop_s && !lane_mis_s) begin
                        adr_r   <= {xalu[XLEN-1:2], 2'b00};
                        dto_r   <= lane_dto_s;
                        sel_r   <= lane_sel_s;
                        wre_r   <= (xopc == OPC_STORE);
                        stb_r   <= 1'b1;
                        xsel_r  <= lane_sel_s;
`ifdef T5_DWB_TIMEOUT_EN
                        tcnt_r  <= '0;
`endif
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (dwb_ack) begin
                        stb_r   <= 1'b0;
                        if (!wre_r) begin
                            ldat_r <= dwb_dti;
                        end
                        xstb_r  <= ~wre_r;
                        xwre_r  <= wre_r;
                        state_r <= ST_DONE;
`ifdef T5_DWB_TIMEOUT_EN
                    end else if (tcnt_r == TW'(TMO - 1)) begin
                        stb_r   <= 1'b0;
                        ldat_r  <= '0;
                        xstb_r  <= ~wre_r;
                        xwre_r  <= wre_r;
                        dtmo_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        tcnt_r  <= tcnt_r + TW'(1);
                        state_r <= ST_BUSY;
`else
                    end else begin
                        state_r <= ST_BUSY;
`endif
                    end
                end
                ST_DONE: begin
                    xsel_r  <= 4'h0;
                    xstb_r  <= 1'b0;
                    xwre_r  <= 1'b0;
`ifdef T5_DWB_TIMEOUT_EN
                    dtmo_r  <= 1'b0;
`endif
                    state_r <= ST_IDLE;
                end
                default: begin
                    stb_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dwb_adr = adr_r;
    assign dwb_dto = dto_r;
    assign dwb_sel = sel_r;
    assign dwb_stb = stb_r;
    assign dwb_wre = wre_r;
    assign xsel    = xsel_r;
    assign xstb    = xstb_r;
    assign xwre    = xwre_r;
    assign ldat    = ldat_r;
`ifdef T5_DWB_TIMEOUT_EN
    assign dtmo    = dtmo_r;
`endif

endmodule
